// File: rtl/arb_burst_sequencer.sv
// arb_burst_sequencer
//   Holds one burst descriptor per agent, raises the matching arbiter request,
//   and on grant streams the burst beats to the shared target.
//   Each finished burst produces a one-cycle end_transaction/done pulse.
//   A DRAIN state waits for the arbiter to drop its grant, so a stale grant
//   is never consumed twice.
module arb_burst_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [3:0]          desc_valid,
  output logic [3:0]          desc_ready,
  input  logic [4*ADDR_W-1:0] desc_addr,
  input  logic [4*LEN_W-1:0]  desc_len,
  output logic [3:0]          request,
  input  logic [3:0]          grant,
  output logic [3:0]          end_transaction,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_id,
  output logic                mem_last,
  output logic [3:0]          done,
  output logic                grant_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_END   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // True when exactly one bit of a 4-bit vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

  // Index of the set bit of a one-hot 4-bit vector.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [ADDR_W-1:0] slot_addr_q [4];
  logic [ADDR_W-1:0] slot_addr_d [4];
  logic [LEN_W-1:0]  slot_len_q  [4];
  logic [LEN_W-1:0]  slot_len_d  [4];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        id_q, id_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_last_q, mem_last_d;
  logic [3:0]        end_q, end_d;
  logic              grant_err_q, grant_err_d;
  logic [1:0]        id_sel_s;

  // Next-state logic: descriptor capture plus the burst FSM.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    slot_addr_d = slot_addr_q;
    slot_len_d  = slot_len_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    mem_valid_d = mem_valid_q;
    mem_last_d  = mem_last_q;
    end_d       = 4'h0;
    grant_err_d = grant_err_q;
    id_sel_s    = enc4(grant);

    // A slot is free whenever its pending bit is low; every agent is independent.
    for (int i = 0; i < 4; i++) begin
      if (desc_valid[i] && !pending_q[i]) begin
        slot_addr_d[i] = desc_addr[i*ADDR_W +: ADDR_W];
        slot_len_d[i]  = desc_len[i*LEN_W +: LEN_W];
        pending_d[i]   = 1'b1;
      end else begin
        pending_d[i]   = pending_q[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant == 4'h0) begin
          state_d = ST_IDLE;
        end else if (is_onehot4(grant) && ((grant & pending_q) != 4'h0)) begin
          id_d        = id_sel_s;
          addr_d      = slot_addr_q[id_sel_s];
          cnt_d       = slot_len_q[id_sel_s];
          mem_valid_d = 1'b1;
          mem_last_d  = (slot_len_q[id_sel_s] == LEN_W'(0));
          state_d     = ST_BURST;
        end else begin
          grant_err_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (grant != (4'b0001 << id_q)) begin
          grant_err_d = 1'b1;
        end else begin
          grant_err_d = grant_err_q;
        end
        if (mem_ready) begin
          if (cnt_q == LEN_W'(0)) begin
            mem_valid_d = 1'b0;
            mem_last_d  = 1'b0;
            end_d       = 4'b0001 << id_q;
            state_d     = ST_END;
          end else begin
            cnt_d      = cnt_q - LEN_W'(1);
            addr_d     = addr_q + ADDR_W'(1);
            mem_last_d = (cnt_q == LEN_W'(1));
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_END: begin
        if (grant != (4'b0001 << id_q)) begin
          grant_err_d = 1'b1;
        end else begin
          grant_err_d = grant_err_q;
        end
        pending_d[id_q] = 1'b0;
        state_d         = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (grant == 4'h0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial burst without a pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      pending_q   <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        slot_addr_q[i] <= '0;
        slot_len_q[i]  <= '0;
      end
      addr_q      <= '0;
      cnt_q       <= '0;
      id_q        <= 2'd0;
      mem_valid_q <= 1'b0;
      mem_last_q  <= 1'b0;
      end_q       <= 4'h0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      slot_addr_q <= slot_addr_d;
      slot_len_q  <= slot_len_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      mem_valid_q <= mem_valid_d;
      mem_last_q  <= mem_last_d;
      end_q       <= end_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign desc_ready      = ~pending_q;
  assign request         = pending_q;
  assign end_transaction = end_q;
  assign done            = end_q;
  assign mem_valid       = mem_valid_q;
  assign mem_addr        = addr_q;
  assign mem_id          = id_q;
  assign mem_last        = mem_last_q;
  assign grant_err       = grant_err_q;

endmodule

// File: tb/tb_arb_burst_sequencer.sv
// Directed bench for arb_burst_sequencer with a small registered
// round-robin arbiter model; grant can instead be driven directly.
module tb_arb_burst_sequencer;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  desc_valid;
  logic [3:0]  desc_ready;
  logic [31:0] desc_addr;
  logic [15:0] desc_len;
  logic [3:0]  request;
  logic [3:0]  grant_s;
  logic [3:0]  end_transaction;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_id;
  logic        mem_last;
  logic [3:0]  done;
  logic        grant_err;

  logic        use_arb;
  logic [3:0]  grant_drv;
  logic [3:0]  arb_grant;
  logic [1:0]  rr_last;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  int end_cnt  = 0;

  arb_burst_sequencer #(.ADDR_W(8), .LEN_W(4)) dut (
    .clk(clk), .rstb(rstb),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .request(request), .grant(grant_s), .end_transaction(end_transaction),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_id(mem_id), .mem_last(mem_last), .done(done), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  assign grant_s = use_arb ? arb_grant : grant_drv;

  // Round-robin pick: first requester after the last winner, {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    for (int off = 1; off <= 4; off++) begin
      idx = last + 2'(off);
      if (req[idx]) return {1'b1, idx};
    end
    return 3'b000;
  endfunction

  // Arbiter model: registered grant, cleared the cycle after end_transaction.
  always @(posedge clk or negedge rstb) begin
    logic [2:0] p;
    if (!rstb) begin
      arb_grant <= 4'h0;
      rr_last   <= 2'd3;
    end else if (arb_grant == 4'h0) begin
      p = rr_pick(request, rr_last);
      if (p[2]) begin
        arb_grant <= 4'b0001 << p[1:0];
        rr_last   <= p[1:0];
      end
    end else if ((end_transaction & arb_grant) != 4'h0) begin
      arb_grant <= 4'h0;
    end
  end

  // Pulse counters for the once-only and no-pulse-on-reset checks.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
    if (end_transaction != 4'h0) end_cnt <= end_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
    tick();
  endtask

  task automatic post(input int a, input logic [7:0] addr, input logic [3:0] len);
    desc_addr[a*8 +: 8] = addr;
    desc_len[a*4 +: 4]  = len;
    desc_valid          = 4'b0001 << a;
    tick();
    desc_valid          = 4'h0;
  endtask

  task automatic wait_valid(input string tag);
    int  n  = 0;
    logic ok;
    while (!mem_valid && n < 20) begin
      tick();
      n++;
    end
    ok = mem_valid;
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_end(input string tag, input logic [3:0] mask);
    int  n  = 0;
    logic ok;
    while ((end_transaction & mask) == 4'h0 && n < 40) begin
      tick();
      n++;
    end
    ok = ((end_transaction & mask) != 4'h0);
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0] e;
    int snap [4];
    int esnap;

    rstb = 1'b0; desc_valid = 4'h0; desc_addr = '0; desc_len = '0;
    mem_ready = 1'b0; use_arb = 1'b1; grant_drv = 4'h0;
    repeat (3) tick();
    check("rst_desc_ready", 32'(desc_ready), 32'hF);
    check("rst_request",    32'(request),    32'h0);
    check("rst_mem_valid",  32'(mem_valid),  32'h0);
    check("rst_end",        32'(end_transaction), 32'h0);
    check("rst_done",       32'(done),       32'h0);
    check("rst_grant_err",  32'(grant_err),  32'h0);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    rstb = 1'b1;
    tick();

    // 1: agent0 burst 0x10..0x13
    mem_ready = 1'b1;
    post(0, 8'h10, 4'd3);
    check("t1_request", 32'(request), 32'h1);
    check("t1_ready",   32'(desc_ready), 32'hE);
    wait_valid("t1_wait_valid");
    for (int k = 0; k < 4; k++) begin
      check("t1_addr", 32'(mem_addr), 32'h10 + 32'(k));
      check("t1_id",   32'(mem_id),   32'd0);
      check("t1_last", 32'(mem_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("t1_end",      32'(end_transaction), 32'h1);
    check("t1_done",     32'(done),            32'h1);
    check("t1_valid_lo", 32'(mem_valid),       32'h0);
    check("t1_req_end",  32'(request),         32'h1);
    tick();
    check("t1_end_off",  32'(end_transaction), 32'h0);
    check("t1_req_lo",   32'(request),         32'h0);
    check("t1_ready_f",  32'(desc_ready),      32'hF);
    tick();
    tick();

    // 2: all four agents, len=0, round-robin order 0..3
    do_reset();
    for (int i = 0; i < 4; i++) snap[i] = done_cnt[i];
    desc_addr = 32'h23222120;
    desc_len  = 16'h0000;
    desc_valid = 4'hF;
    tick();
    desc_valid = 4'h0;
    check("t2_request", 32'(request), 32'hF);
    for (int i = 0; i < 4; i++) begin
      wait_end("t2_wait_end", 4'hF);
      check("t2_order_end",  32'(end_transaction), 32'(4'b0001 << i));
      check("t2_order_done", 32'(done),            32'(4'b0001 << i));
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) check("t2_done_once", 32'(done_cnt[i] - snap[i]), 32'd1);

    // 3: address wrap with mem_ready stalls
    mem_ready = 1'b0;
    post(2, 8'hFE, 4'd3);
    wait_valid("t3_wait_valid");
    for (int k = 0; k < 4; k++) begin
      e = 8'hFE + 8'(k);
      mem_ready = 1'b1;
      check("t3_addr", 32'(mem_addr), 32'(e));
      check("t3_id",   32'(mem_id),   32'd2);
      check("t3_last", 32'(mem_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
      if (k < 3) begin
        e = e + 8'd1;
        mem_ready = 1'b0;
        check("t3_next_addr", 32'(mem_addr), 32'(e));
        tick();
        check("t3_stall_addr",  32'(mem_addr),  32'(e));
        check("t3_stall_valid", 32'(mem_valid), 32'd1);
      end
    end
    check("t3_end", 32'(end_transaction), 32'h4);
    mem_ready = 1'b1;
    repeat (3) tick();

    // 4: illegal grants
    use_arb = 1'b0;
    grant_drv = 4'b0011;
    tick();
    check("t4_multi_err",   32'(grant_err), 32'd1);
    check("t4_multi_valid", 32'(mem_valid), 32'd0);
    grant_drv = 4'h0;
    tick();
    check("t4_multi_idle", 32'(mem_valid), 32'd0);
    do_reset();
    check("t4_err_cleared", 32'(grant_err), 32'd0);
    grant_drv = 4'b0100;
    tick();
    check("t4_np_err",   32'(grant_err), 32'd1);
    check("t4_np_valid", 32'(mem_valid), 32'd0);
    grant_drv = 4'h0;
    post(0, 8'h55, 4'd0);
    grant_drv = 4'b0001;
    tick();
    check("t4_still_idle_valid", 32'(mem_valid), 32'd1);
    check("t4_still_idle_addr",  32'(mem_addr),  32'h55);
    tick();
    check("t4_end", 32'(end_transaction), 32'h1);
    grant_drv = 4'h0;
    tick();
    tick();
    use_arb = 1'b1;
    do_reset();

    // 5: reset during second beat of a len=7 burst
    esnap = end_cnt;
    post(3, 8'h40, 4'd7);
    wait_valid("t5_wait_valid");
    tick();
    check("t5_beat2_addr", 32'(mem_addr), 32'h41);
    rstb = 1'b0;
    #1;
    check("t5_rst_valid",   32'(mem_valid),  32'd0);
    check("t5_rst_ready",   32'(desc_ready), 32'hF);
    check("t5_rst_request", 32'(request),    32'h0);
    check("t5_rst_end",     32'(end_transaction), 32'h0);
    check("t5_rst_addr",    32'(mem_addr),   32'h0);
    tick();
    rstb = 1'b1;
    repeat (4) tick();
    check("t5_no_end_pulse", 32'(end_cnt - esnap), 32'd0);
    check("t5_idle_valid",   32'(mem_valid),       32'd0);

    // 6: agent1 descriptor held through its own END
    desc_addr[8 +: 8] = 8'h30;
    desc_len[4 +: 4]  = 4'd1;
    desc_valid = 4'b0010;
    wait_end("t6_wait_end", 4'b0010);
    check("t6_req_in_end",   32'(request),    32'h2);
    check("t6_ready_in_end", 32'(desc_ready), 32'hD);
    tick();
    check("t6_req_low",  32'(request),    32'h0);
    check("t6_ready_hi", 32'(desc_ready), 32'hF);
    tick();
    check("t6_req_rise", 32'(request), 32'h2);
    desc_valid = 4'h0;
    wait_end("t6_wait_end2", 4'b0010);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
